pcpu_mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the pipeline's instruction-fetch port (IF) and data-memory port (DM, Mem stage).
- Arbitrates between the two ports, drives the memory through a req/ack handshake, returns read data and a one-cycle ready pulse to the winning port, and generates stall signals for the pipeline.
- DM has default priority; a starvation counter guarantees IF forward progress.

---
 rtl/pcpu_mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_pcpu_mem_arbiter.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcpu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// pcpu_mem_arbiter
//
// Shares one single-port unified memory between the pipeline's instruction
// fetch port (IF) and data memory port (DM). DM wins by default; a starvation
// counter forces an IF grant after STARVE_MAX consecutive contended losses.
// The memory is driven through a req/ack handshake (mem_en held until mem_ack).
// Each completed access returns a one-cycle ready pulse to the port that won it.
//
// Parameters
//   STARVE_MAX : contended arbitrations IF may lose before it is forced (1..15)
//   ADDR_W     : address width
//
// Ports
//   clk, rst                  : clock, asynchronous active-low reset
//   if_req/if_addr            : IF fetch request (held until if_ready)
//   if_rdata/if_ready         : fetched word, one-cycle completion pulse
//   dm_req/dm_we/dm_addr/
//   dm_wdata                  : DM request (held until dm_ready)
//   dm_rdata/dm_ready         : DM read data, one-cycle completion pulse
//   stall_if/stall_mem        : pipeline stalls, req & ~ready
//   mem_en/mem_we/mem_addr/
//   mem_wdata                 : memory request, held stable until mem_ack
//   mem_rdata/mem_ack         : memory response
//
// Optional feature (macro ARB_PERF_CNT_EN)
//   perf_if_stall, perf_dm_stall, perf_forced : free-running 32-bit counters
// -----------------------------------------------------------------------------
module pcpu_mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_stall,
    output logic [31:0]       perf_dm_stall,
    output logic [31:0]       perf_forced
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state, state_nxt;
    logic [3:0] starve_cnt, starve_nxt;

    logic if_elig, dm_elig;
    logic grant_if, grant_dm, forced;

    // A port whose ready is pulsing this cycle is already served; ignoring its
    // still-high req keeps one request from being granted twice.
    assign if_elig = if_req & ~if_ready;
    assign dm_elig = dm_req & ~dm_ready;

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        forced     = 1'b0;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        case (state)
            IDLE: begin
                forced   = if_elig & dm_elig & (starve_cnt >= STARVE_LIM);
                grant_if = forced | (if_elig & ~dm_elig);
                grant_dm = dm_elig & ~grant_if;
                if (grant_if) begin
                    state_nxt  = BUSY_IF;
                    starve_nxt = '0;
                end else if (grant_dm) begin
                    state_nxt = BUSY_DM;
                    // Only a contended DM win counts against IF.
                    if (if_elig) begin
                        starve_nxt = starve_cnt + 4'd1;
                    end
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Memory request and response registers. A reset while busy simply drops
    // mem_en; no ready pulse is produced for the aborted access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            if (grant_if) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end else if (grant_dm) begin
                mem_en    <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (mem_ack && state != IDLE) begin
                mem_en <= 1'b0;
                if (state == BUSY_IF) begin
                    if_ready <= 1'b1;
                    if_rdata <= mem_rdata;
                end else begin
                    dm_ready <= 1'b1;
                    if (!mem_we) begin
                        dm_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_if_stall <= '0;
            perf_dm_stall <= '0;
            perf_forced   <= '0;
        end else begin
            perf_if_stall <= perf_if_stall + 32'(stall_if);
            perf_dm_stall <= perf_dm_stall + 32'(stall_mem);
            perf_forced   <= perf_forced + 32'(forced);
        end
    end
`endif

endmodule

// File: tb/tb_pcpu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pcpu_mem_arbiter
//
// Self-checking bench for pcpu_mem_arbiter. The bench also plays the two
// requesters and the memory. A transaction-level reference tracks the current
// memory owner and IF's contended losses, and predicts every visible output
// each cycle. Directed scenarios come first, followed by a randomized soak.
// -----------------------------------------------------------------------------
module tb_pcpu_mem_arbiter;

    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned ADDR_W     = 32;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ready;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;
    logic              dm_ready;
    logic              stall_if;
    logic              stall_mem;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]       perf_if_stall;
    logic [31:0]       perf_dm_stall;
    logic [31:0]       perf_forced;
`endif

    pcpu_mem_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_stall (perf_if_stall),
        .perf_dm_stall (perf_dm_stall),
        .perf_forced   (perf_forced)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          owner;      // 0 = memory free, 1 = IF owns it, 2 = DM owns it
    int unsigned losses;     // contended arbitrations IF has lost in a row
    logic        e_en, e_we, e_if_ready, e_dm_ready;
    logic [31:0] e_addr, e_wdata, e_if_rdata, e_dm_rdata;
    logic [31:0] e_perf_if, e_perf_dm, e_perf_forced;

    // ---------------- memory model / stimulus state ----------------
    logic [31:0] mem_arr [64];
    bit          spurious_en;
    bit          busy_seen;
    int          ack_min, ack_max, wait_left;

    task automatic model_reset();
        owner         = 0;
        losses        = 0;
        e_en          = 1'b0;
        e_we          = 1'b0;
        e_addr        = '0;
        e_wdata       = '0;
        e_if_rdata    = '0;
        e_dm_rdata    = '0;
        e_if_ready    = 1'b0;
        e_dm_ready    = 1'b0;
        e_perf_if     = '0;
        e_perf_dm     = '0;
        e_perf_forced = '0;
        busy_seen     = 1'b0;
    endtask

    // Advance the reference by one rising edge using the inputs present before it.
    task automatic model_step();
        logic if_ok, dm_ok, nif, ndm;
        int   win;
        if_ok = if_req & ~e_if_ready;
        dm_ok = dm_req & ~e_dm_ready;
        nif   = 1'b0;
        ndm   = 1'b0;
        if (if_ok) e_perf_if++;
        if (dm_ok) e_perf_dm++;
        if (owner != 0) begin
            if (mem_ack) begin
                if (owner == 1) begin
                    nif        = 1'b1;
                    e_if_rdata = mem_rdata;
                end else begin
                    ndm = 1'b1;
                    if (e_we) mem_arr[e_addr[7:2]] = e_wdata;
                    else      e_dm_rdata = mem_rdata;
                end
                owner = 0;
                e_en  = 1'b0;
            end
        end else begin
            win = 0;
            if (if_ok && dm_ok) begin
                if (losses >= STARVE_MAX) begin
                    win = 1;
                    e_perf_forced++;
                end else begin
                    win = 2;
                    losses++;
                end
            end else if (if_ok) begin
                win = 1;
            end else if (dm_ok) begin
                win = 2;
            end
            if (win == 1) begin
                losses = 0;
                e_en   = 1'b1;
                e_we   = 1'b0;
                e_addr = if_addr;
            end else if (win == 2) begin
                e_en    = 1'b1;
                e_we    = dm_we;
                e_addr  = dm_addr;
                e_wdata = dm_wdata;
            end
            owner = win;
        end
        e_if_ready = nif;
        e_dm_ready = ndm;
    endtask

    task automatic compare_regs();
        check("mem_en", mem_en, e_en);
        check("mem_we", mem_we, e_we);
        if (e_en) check("mem_addr", mem_addr, e_addr);
        if (e_en && e_we) check("mem_wdata", mem_wdata, e_wdata);
        check("if_ready", if_ready, e_if_ready);
        check("dm_ready", dm_ready, e_dm_ready);
        check("if_rdata", if_rdata, e_if_rdata);
        check("dm_rdata", dm_rdata, e_dm_rdata);
`ifdef ARB_PERF_CNT_EN
        check("perf_if_stall", perf_if_stall, e_perf_if);
        check("perf_dm_stall", perf_dm_stall, e_perf_dm);
        check("perf_forced", perf_forced, e_perf_forced);
`endif
    endtask

    // Memory side: ack after a chosen number of cycles with mem_en high,
    // optionally throwing spurious acks while the memory is idle.
    task automatic mem_drive();
        if (e_en) begin
            if (!busy_seen) begin
                busy_seen = 1'b1;
                wait_left = int'($urandom_range(ack_max, ack_min));
            end
            if (wait_left == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_arr[e_addr[7:2]];
            end else begin
                wait_left--;
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
        end else begin
            busy_seen = 1'b0;
            mem_ack   = spurious_en && ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
        end
    endtask

    task automatic cycle();
        #1;
        check("stall_if", stall_if, if_req & ~e_if_ready);
        check("stall_mem", stall_mem, dm_req & ~e_dm_ready);
        @(posedge clk);
        model_step();
        #1;
        compare_regs();
    endtask

    task automatic step();
        mem_drive();
        cycle();
    endtask

    task automatic wait_port(input int port, input int max_cyc, input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            step();
            if ((port == 1 && e_if_ready) || (port == 2 && e_dm_ready)) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    task automatic drive_random();
        if (if_req) begin
            if (e_if_ready) begin
                if ($urandom_range(0, 1) == 0) if_req = 1'b0;
                else                           if_addr = rand_addr();
            end else if (owner == 1) begin
                if ($urandom_range(0, 15) == 0) begin
                    if_req  = 1'b0;
                    if_addr = rand_addr();
                end
            end else if ($urandom_range(0, 31) == 0) begin
                if_req = 1'b0;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            if_req  = 1'b1;
            if_addr = rand_addr();
        end

        if (dm_req) begin
            if (e_dm_ready) begin
                if ($urandom_range(0, 1) == 0) begin
                    dm_req = 1'b0;
                end else begin
                    dm_addr  = rand_addr();
                    dm_we    = 1'($urandom_range(0, 1));
                    dm_wdata = $urandom;
                end
            end else if (owner == 2) begin
                if ($urandom_range(0, 15) == 0) begin
                    dm_req   = 1'b0;
                    dm_addr  = rand_addr();
                    dm_wdata = $urandom;
                end
            end
        end else if ($urandom_range(0, 2) == 0) begin
            dm_req   = 1'b1;
            dm_addr  = rand_addr();
            dm_we    = 1'($urandom_range(0, 1));
            dm_wdata = $urandom;
        end
    endtask

    initial begin
        int pulses;
        logic [31:0] exp_addr;

        for (int i = 0; i < 64; i++) mem_arr[i] = $urandom;
        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        ack_min   = 0;
        ack_max   = 0;
        wait_left = 0;
        model_reset();

        // Reset state.
        #1;
        check("rst_mem_en", mem_en, 0);
        check("rst_if_ready", if_ready, 0);
        check("rst_dm_ready", dm_ready, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_stall_if", stall_if, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // Idle with stray acks: nothing must move.
        spurious_en = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("idle_mem_en", mem_en, 0);

        // Single IF read, ack two cycles after mem_en rises.
        spurious_en = 1'b0;
        ack_min     = 2;
        ack_max     = 2;
        mem_arr[0]  = 32'h0050_0093;
        if_addr     = 32'h100;
        if_req      = 1'b1;
        step();
        check("if_grant_en", mem_en, 1);
        check("if_grant_addr", mem_addr, 32'h100);
        check("if_grant_we", mem_we, 0);
        pulses = -1;
        for (int c = 0; c < 20; c++) begin
            check("if_wait_stall", stall_if, 1);
            step();
            if (e_if_ready) begin
                pulses = c;
                break;
            end
        end
        check("if_latency", pulses, 2);
        check("if_ready_pulse", if_ready, 1);
        check("if_fetch_data", if_rdata, 32'h0050_0093);
        if_req = 1'b0;
        step();
        check("if_ready_once", if_ready, 0);

        // DM write; dm_rdata must stay at its reset value.
        ack_min  = 1;
        ack_max  = 1;
        dm_addr  = 32'h2000;
        dm_we    = 1'b1;
        dm_wdata = 32'hDEAD_BEEF;
        dm_req   = 1'b1;
        step();
        check("dm_wr_we", mem_we, 1);
        check("dm_wr_addr", mem_addr, 32'h2000);
        check("dm_wr_data", mem_wdata, 32'hDEAD_BEEF);
        wait_port(2, 20, "dm_wr_done");
        check("dm_wr_rdata", dm_rdata, 32'h0);
        dm_req = 1'b0;
        dm_we  = 1'b0;
        step();

        // Starvation: both raise together in IDLE and the loser withdraws.
        // IF loses four contended rounds, the fifth is forced to IF.
        ack_min = 0;
        ack_max = 0;
        if_addr = 32'h40;
        dm_addr = 32'h80;
        for (int r = 0; r < 6; r++) begin
            if_req = 1'b1;
            dm_req = 1'b1;
            step();
            exp_addr = (r == 4) ? 32'h40 : 32'h80;
            check("starve_winner", mem_addr, exp_addr);
`ifdef ARB_PERF_CNT_EN
            if (r == 4) check("perf_forced_once", perf_forced, 1);
`endif
            if_req = 1'b0;
            dm_req = 1'b0;
            for (int i = 0; i < 4; i++) step();
        end

        // Back-to-back: IF waits behind DM and wins in the dm_ready cycle
        // while DM still holds its req.
        ack_min = 1;
        ack_max = 1;
        dm_addr = 32'h84;
        dm_req  = 1'b1;
        step();
        if_addr = 32'h44;
        if_req  = 1'b1;
        wait_port(2, 20, "b2b_dm_done");
        check("b2b_ready_idle", mem_en, 0);
        step();
        check("b2b_if_en", mem_en, 1);
        check("b2b_if_addr", mem_addr, 32'h44);
        dm_req = 1'b0;
        wait_port(1, 20, "b2b_if_done");
        if_req = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Abandoned IF request still completes with exactly one pulse.
        ack_min = 3;
        ack_max = 3;
        if_addr = 32'h48;
        if_req  = 1'b1;
        step();
        check("abandon_addr", mem_addr, 32'h48);
        if_req  = 1'b0;
        if_addr = 32'hFC;
        pulses  = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (if_ready) pulses++;
        end
        check("abandon_pulses", pulses, 1);

        // Reset in the middle of a DM read.
        dm_addr = 32'h88;
        dm_we   = 1'b0;
        dm_req  = 1'b1;
        step();
        step();
        check("mid_busy_en", mem_en, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_mem_en", mem_en, 0);
        check("arst_mem_we", mem_we, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_mem_wdata", mem_wdata, 0);
        check("arst_if_rdata", if_rdata, 0);
        check("arst_dm_rdata", dm_rdata, 0);
        check("arst_dm_ready", dm_ready, 0);
        check("arst_if_ready", if_ready, 0);
        dm_req  = 1'b0;
        mem_ack = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        spurious_en = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Randomized soak.
        ack_min = 0;
        ack_max = 3;
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
